// File: rtl/fnd_multi_channel_display.sv
// Multi-channel FND driver: picks one of NUM_CH register channels (one-hot or auto-rotate),
// captures it once per scan frame, renders hex or blanked decimal and scans common-anode digits.
module fnd_multi_channel_display #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int AUTO_DIV   = 100000000,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]          sel,
  input  logic                       auto_en,
  input  logic                       hex_mode,
  output logic [7:0]                 fndFont,
  output logic [NUM_DIGITS-1:0]      fndCom,
  output logic [CH_W-1:0]            cur_ch,
  output logic                       sel_err
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_D  = (DATA_W * 301) / 1000 + 1;
  localparam int BCD_W  = BCD_D * 4;
  localparam int PAD_D  = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
  localparam int HEX_W  = (DATA_W > NUM_DIGITS * 4) ? DATA_W : NUM_DIGITS * 4;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} conv_state_e;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_D; i++) begin
      r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
    end
    return r;
  endfunction

  logic [SCAN_W-1:0]         scan_cnt_r;
  logic [DIG_W-1:0]          dig_idx_r;
  logic                      frame_tick_r;
  logic [AUTO_W-1:0]         auto_cnt_r;
  logic [CH_W-1:0]           ch_idx_r;
  logic                      sel_err_r;
  logic [CH_W-1:0]           cur_ch_r;
  logic [DATA_W-1:0]         cap_val_r;
  logic                      hex_load_r;
  conv_state_e               state_r, state_nxt_s;
  logic [BCD_W-1:0]          bcd_r;
  logic [DATA_W-1:0]         bin_r;
  logic [CNT_W-1:0]          bit_cnt_r;
  logic [NUM_DIGITS*8-1:0]   disp_r;
  logic [7:0]                font_r;
  logic [NUM_DIGITS-1:0]     com_r;

  logic                      scan_tc_s;
  logic                      onehot_s;
  logic [CH_W-1:0]           sel_idx_s;
  logic [DATA_W-1:0]         cap_next_s;
  logic                      conv_start_s;
  logic                      conv_load_s;
  logic [BCD_W-1:0]          bcd_adj_s;
  logic [HEX_W-1:0]          hex_pad_s;
  logic [PAD_D*4-1:0]        bcd_pad_s;
  logic [NUM_DIGITS*8-1:0]   hex_seg_s;
  logic [NUM_DIGITS*8-1:0]   dec_seg_s;
  logic                      ovf_s;
  logic                      shown_s;

  assign scan_tc_s    = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));
  assign cap_next_s   = sel_err_r ? {DATA_W{1'b0}} : ch_data[ch_idx_r*DATA_W +: DATA_W];
  assign conv_start_s = (state_r == ST_IDLE) && frame_tick_r && !hex_mode;
  assign bcd_adj_s    = dd_adjust(bcd_r);

  // Manual select decode: one-hot check and bit position
  always_comb begin
    onehot_s  = (sel != {NUM_CH{1'b0}}) && ((sel & (sel - NUM_CH'(1))) == {NUM_CH{1'b0}});
    sel_idx_s = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      sel_idx_s = sel[k] ? CH_W'(k) : sel_idx_s;
    end
  end

  // Digit scan counters and frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_r   <= {SCAN_W{1'b0}};
      dig_idx_r    <= {DIG_W{1'b0}};
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= 1'b0;
      if (scan_tc_s) begin
        scan_cnt_r <= {SCAN_W{1'b0}};
        if (dig_idx_r == DIG_W'(NUM_DIGITS - 1)) begin
          dig_idx_r    <= {DIG_W{1'b0}};
          frame_tick_r <= 1'b1;
        end else begin
          dig_idx_r <= dig_idx_r + DIG_W'(1);
        end
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end
    end
  end

  // Channel selection (manual or auto-rotate) and per-frame capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
      ch_idx_r   <= {CH_W{1'b0}};
      sel_err_r  <= 1'b0;
      cur_ch_r   <= {CH_W{1'b0}};
      cap_val_r  <= {DATA_W{1'b0}};
      hex_load_r <= 1'b0;
    end else begin
      sel_err_r  <= !auto_en && !onehot_s;
      hex_load_r <= frame_tick_r && hex_mode;
      if (auto_en) begin
        if (auto_cnt_r == AUTO_W'(AUTO_DIV - 1)) begin
          auto_cnt_r <= {AUTO_W{1'b0}};
          ch_idx_r   <= (ch_idx_r == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : ch_idx_r + CH_W'(1);
        end else begin
          auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
        end
      end else begin
        auto_cnt_r <= {AUTO_W{1'b0}};
        if (onehot_s) ch_idx_r <= sel_idx_s;
      end
      if (frame_tick_r) begin
        cap_val_r <= cap_next_s;
        cur_ch_r  <= ch_idx_r;
      end
    end
  end

  // Converter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Converter next-state logic
  always_comb begin
    state_nxt_s = state_r;
    conv_load_s = 1'b0;
    case (state_r)
      ST_IDLE:  state_nxt_s = conv_start_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_nxt_s = (bit_cnt_r == CNT_W'(DATA_W - 1)) ? ST_DONE : ST_SHIFT;
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        conv_load_s = 1'b1;
      end
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Double-dabble datapath: one add-3-then-shift step per SHIFT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_r     <= {BCD_W{1'b0}};
      bin_r     <= {DATA_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (conv_start_s) begin
      bcd_r     <= {BCD_W{1'b0}};
      bin_r     <= cap_next_s;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_SHIFT) begin
      {bcd_r, bin_r} <= {bcd_adj_s[BCD_W-2:0], bin_r, 1'b0};
      bit_cnt_r      <= bit_cnt_r + CNT_W'(1);
    end
  end

  // Segment rendering for both modes; decimal blanks leading zeros and dashes on overflow
  always_comb begin
    logic [3:0] dig_v;
    hex_pad_s = {HEX_W{1'b0}};
    hex_pad_s[DATA_W-1:0] = cap_val_r;
    bcd_pad_s = {(PAD_D*4){1'b0}};
    bcd_pad_s[BCD_W-1:0] = bcd_r;
    hex_seg_s = {NUM_DIGITS{8'hFF}};
    dec_seg_s = {NUM_DIGITS{8'hFF}};
    ovf_s     = 1'b0;
    shown_s   = 1'b0;
    dig_v     = 4'd0;
    for (int i = NUM_DIGITS; i < PAD_D; i++) begin
      ovf_s = ovf_s | (bcd_pad_s[i*4 +: 4] != 4'd0);
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig_v   = bcd_pad_s[i*4 +: 4];
      shown_s = shown_s | (dig_v != 4'd0) | (i == 0);
      dec_seg_s[i*8 +: 8] = ovf_s ? 8'hBF : (shown_s ? seg7(dig_v) : 8'hFF);
      hex_seg_s[i*8 +: 8] = seg7(hex_pad_s[i*4 +: 4]);
    end
  end

  // Display register and registered pin drivers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_r <= {NUM_DIGITS{8'hFF}};
      font_r <= 8'hFF;
      com_r  <= {NUM_DIGITS{1'b1}};
    end else begin
      if (hex_load_r)       disp_r <= hex_seg_s;
      else if (conv_load_s) disp_r <= dec_seg_s;
      com_r  <= ~(NUM_DIGITS'(1) << dig_idx_r);
      font_r <= {~(auto_en && (dig_idx_r == DIG_W'(NUM_DIGITS - 1))), disp_r[dig_idx_r*8 +: 7]};
    end
  end

  assign fndFont = font_r;
  assign fndCom  = com_r;
  assign cur_ch  = cur_ch_r;
  assign sel_err = sel_err_r;

endmodule

// File: tb/tb_fnd_multi_channel_display.sv
// Directed bench for fnd_multi_channel_display: an 8-bit/4-channel instance plus a
// 16-bit/2-channel instance for decimal overflow and blanking cases.
module tb_fnd_multi_channel_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ch_data;
  logic [3:0]  sel;
  logic        auto_en;
  logic        hex_mode;
  logic [7:0]  font;
  logic [3:0]  com;
  logic [1:0]  cur_ch;
  logic        sel_err;

  logic [31:0] ch_data16;
  logic [1:0]  sel16;
  logic [7:0]  font16;
  logic [3:0]  com16;
  logic        cur_ch16;
  logic        sel_err16;

  logic        use16;
  logic [3:0]  mon_com;
  logic [7:0]  mon_font;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fnd_multi_channel_display #(.NUM_CH(4), .DATA_W(8), .NUM_DIGITS(4), .SCAN_DIV(8), .AUTO_DIV(128)) u_dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .sel(sel), .auto_en(auto_en), .hex_mode(hex_mode),
    .fndFont(font), .fndCom(com), .cur_ch(cur_ch), .sel_err(sel_err));

  fnd_multi_channel_display #(.NUM_CH(2), .DATA_W(16), .NUM_DIGITS(4), .SCAN_DIV(24), .AUTO_DIV(128)) u_dut16 (
    .clk(clk), .reset(reset), .ch_data(ch_data16), .sel(sel16), .auto_en(1'b0), .hex_mode(1'b0),
    .fndFont(font16), .fndCom(com16), .cur_ch(cur_ch16), .sel_err(sel_err16));

  assign mon_com  = use16 ? com16 : com;
  assign mon_font = use16 ? font16 : font;

  // Wait (bounded) for the monitored instance to enable a given digit.
  task automatic wait_com(input logic [3:0] target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mon_com == target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_com: fndCom never reached %b (last %b)", target, mon_com);
    end
  endtask

  // Read one full frame of segment codes, digit 3 in the top byte.
  task automatic read_frame(output logic [31:0] fr);
    fr = 32'h0;
    wait_com(4'b0111);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] tgt;
      tgt = ~(4'b0001 << d);
      wait_com(tgt);
      repeat (4) @(negedge clk);
      fr[d*8 +: 8] = mon_font;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; use16 = 1'b0;
    sel = 4'b0100; auto_en = 1'b0; hex_mode = 1'b0;
    ch_data = {8'd40, 8'd30, 8'd20, 8'd10};
    ch_data16 = 32'h0; sel16 = 2'b01;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    n_tests++;
    if (cur_ch !== 2'd2) begin n_fail++; $display("FAIL pre_reset_cur_ch got %0d want 2", cur_ch); end
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if (font !== 8'hFF) begin n_fail++; $display("FAIL reset_font got %h want ff", font); end
    n_tests++;
    if (com !== 4'hF) begin n_fail++; $display("FAIL reset_com got %b want 1111", com); end
    n_tests++;
    if (cur_ch !== 2'd0 || sel_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got cur_ch=%0d sel_err=%b want 0/0", cur_ch, sel_err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (com !== 4'b1110) begin n_fail++; $display("FAIL first_slot got %b want 1110", com); end
    n_tests++;
    if (cur_ch !== 2'd0) begin n_fail++; $display("FAIL post_reset_cur_ch got %0d want 0", cur_ch); end
  endtask

  task automatic test_decimal;
    logic [31:0] fr;
    logic [7:0]  vals [3];
    logic [31:0] exps [3];
    vals[0] = 8'd123; exps[0] = 32'hFF_F9_A4_B0;
    vals[1] = 8'd7;   exps[1] = 32'hFF_FF_FF_F8;
    vals[2] = 8'd255; exps[2] = 32'hFF_A4_92_92;
    sel = 4'b0010; hex_mode = 1'b0; auto_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ch_data[15:8] = vals[k];
      repeat (80) @(negedge clk);
      read_frame(fr);
      n_tests++;
      if (fr !== exps[k]) begin n_fail++; $display("FAIL dec_%0d got %h want %h", vals[k], fr, exps[k]); end
    end
    n_tests++;
    if (cur_ch !== 2'd1 || sel_err !== 1'b0) begin
      n_fail++; $display("FAIL dec_sel got cur_ch=%0d sel_err=%b want 1/0", cur_ch, sel_err);
    end
  endtask

  task automatic test_hex;
    logic [31:0] fr;
    hex_mode = 1'b1;
    ch_data[15:8] = 8'hAF;
    repeat (80) @(negedge clk);
    read_frame(fr);
    n_tests++;
    if (fr !== 32'hC0_C0_88_8E) begin n_fail++; $display("FAIL hex_af got %h want c0c0888e", fr); end
    wait_com(4'b1101);
    ch_data[15:8] = 8'h36;
    repeat (3) @(negedge clk);
    n_tests++;
    if (font !== 8'h88) begin n_fail++; $display("FAIL hex_no_tear got %h want 88", font); end
    wait_com(4'b0111);
    wait_com(4'b1110);
    repeat (4) @(negedge clk);
    n_tests++;
    if (font !== 8'h82) begin n_fail++; $display("FAIL hex_next_d0 got %h want 82", font); end
    wait_com(4'b1101);
    repeat (4) @(negedge clk);
    n_tests++;
    if (font !== 8'hB0) begin n_fail++; $display("FAIL hex_next_d1 got %h want b0", font); end
  endtask

  task automatic test_sel_err;
    logic [31:0] fr;
    hex_mode = 1'b0;
    ch_data[15:8] = 8'd123;
    @(negedge clk);
    sel = 4'b0110;
    n_tests++;
    if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_latency got %b want 0", sel_err); end
    @(negedge clk);
    n_tests++;
    if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_err_multi got %b want 1", sel_err); end
    sel = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_err_zero got %b want 1", sel_err); end
    repeat (80) @(negedge clk);
    read_frame(fr);
    n_tests++;
    if (fr !== 32'hFF_FF_FF_C0) begin n_fail++; $display("FAIL sel_err_disp got %h want ffffffc0", fr); end
    sel = 4'b0010;
    @(negedge clk);
    n_tests++;
    if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_clear got %b want 0", sel_err); end
    repeat (80) @(negedge clk);
    read_frame(fr);
    n_tests++;
    if (fr !== 32'hFF_F9_A4_B0) begin n_fail++; $display("FAIL sel_err_recover got %h want fff9a4b0", fr); end
  endtask

  task automatic test_auto;
    hex_mode = 1'b1;
    ch_data = {8'h33, 8'h22, 8'h11, 8'h00};
    sel = 4'b0100;
    repeat (2) @(negedge clk);
    auto_en = 1'b1;
    sel = 4'b0000;
    for (int c = 1; c <= 430; c++) begin
      @(negedge clk);
      if (c == 50) begin
        n_tests++;
        if (sel_err !== 1'b0) begin n_fail++; $display("FAIL auto_sel_ignored got %b want 0", sel_err); end
      end
      if (c == 100 || c == 168 || c == 250 || c == 296 || c == 424) begin
        logic [1:0] exp_ch;
        exp_ch = (c < 128) ? 2'd2 : (c < 256) ? 2'd3 : (c < 384) ? 2'd0 : 2'd1;
        n_tests++;
        if (cur_ch !== exp_ch) begin n_fail++; $display("FAIL auto_cur_ch@%0d got %0d want %0d", c, cur_ch, exp_ch); end
      end
    end
    wait_com(4'b0111);
    repeat (2) @(negedge clk);
    n_tests++;
    if (font !== 8'h40) begin n_fail++; $display("FAIL auto_dp_d3 got %h want 40", font); end
    wait_com(4'b1110);
    repeat (4) @(negedge clk);
    n_tests++;
    if (font !== 8'hF9) begin n_fail++; $display("FAIL auto_dp_d0 got %h want f9", font); end
    auto_en = 1'b0;
    sel = 4'b1000;
    repeat (2) @(negedge clk);
    n_tests++;
    if (sel_err !== 1'b0) begin n_fail++; $display("FAIL manual_return_err got %b want 0", sel_err); end
    repeat (80) @(negedge clk);
    n_tests++;
    if (cur_ch !== 2'd3) begin n_fail++; $display("FAIL manual_return_ch got %0d want 3", cur_ch); end
  endtask

  task automatic test_wide;
    logic [31:0] fr;
    logic [15:0] vals [5];
    logic [31:0] exps [5];
    vals[0] = 16'd12345; exps[0] = 32'hBF_BF_BF_BF;
    vals[1] = 16'd9999;  exps[1] = 32'h90_90_90_90;
    vals[2] = 16'd0;     exps[2] = 32'hFF_FF_FF_C0;
    vals[3] = 16'd1000;  exps[3] = 32'hF9_C0_C0_C0;
    vals[4] = 16'd65535; exps[4] = 32'hBF_BF_BF_BF;
    use16 = 1'b1;
    sel16 = 2'b01;
    for (int k = 0; k < 5; k++) begin
      ch_data16[15:0] = vals[k];
      repeat (250) @(negedge clk);
      read_frame(fr);
      n_tests++;
      if (fr !== exps[k]) begin n_fail++; $display("FAIL wide_%0d got %h want %h", vals[k], fr, exps[k]); end
    end
    use16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_sel_err();
    test_auto();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
